// File: rtl/audio_level_meter_pkg.sv
// Shared width helpers and sample conversion for the audio level meters.
package audio_level_meter_pkg;

  function automatic int unsigned ch_width(input int unsigned channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int unsigned pos_width(input int unsigned indicator_width);
    return $clog2(indicator_width + 1);
  endfunction

  function automatic int unsigned count_width(input int unsigned max_value);
    return (max_value > 0) ? $clog2(max_value + 1) : 1;
  endfunction

  // Two's complement to offset binary: flip the sign bit of a w-bit sample.
  function automatic logic [63:0] to_offset(input logic [63:0] v, input int unsigned w);
    return v ^ (64'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/audio_level_meter_multi_l2p.sv
// Combinational section diff to bar position, log2 or linear (ceiling) mapping.
module level_to_position
  import audio_level_meter_pkg::*;
#(
  parameter int unsigned sample_width    = 16,
  parameter int unsigned indicator_width = 32,
  parameter int unsigned log_scale       = 1
) (
  input  logic [sample_width-1:0]                 diff_i,
  output logic [pos_width(indicator_width)-1:0]   pos_o
);

  localparam int unsigned PW = pos_width(indicator_width);

  if (log_scale != 0) begin : g_log
    localparam int unsigned LW = $clog2(sample_width + 1);
    logic [LW-1:0] msb_len;

    // Length of diff in bits: highest set bit index plus one.
    always_comb begin
      msb_len = '0;
      for (int unsigned i = 0; i < sample_width; i++) begin
        if (diff_i[i]) msb_len = LW'(i + 1);
      end
    end

    assign pos_o = PW'((32'(msb_len) * indicator_width) / sample_width);
  end else begin : g_lin
    localparam int unsigned MW = sample_width + PW + 1;
    logic [MW-1:0] scaled;

    assign scaled = MW'(diff_i) * MW'(indicator_width)
                  + MW'((64'(1) << sample_width) - 64'(1));
    assign pos_o  = PW'(scaled >> sample_width);
  end

endmodule

// File: rtl/audio_level_meter_multi.sv
// Time-multiplexed multi-channel level meter: section min/max, position,
// peak hold with decay and bar-graph output over one shared datapath.
module audio_level_meter_multi
  import audio_level_meter_pkg::*;
#(
  parameter int unsigned channels             = 2,
  parameter int unsigned sample_width         = 16,
  parameter int unsigned indicator_width      = 32,
  parameter int unsigned section_sample_count = 32,
  parameter int unsigned peak_hold_count      = 13781,
  parameter int unsigned log_scale            = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   i_valid,
  output logic                                   i_ready,
  input  logic [ch_width(channels)-1:0]          i_channel,
  input  logic [sample_width-1:0]                i_value,
  output logic                                   o_valid,
  input  logic                                   o_ready,
  output logic [ch_width(channels)-1:0]          o_channel,
  output logic [pos_width(indicator_width)-1:0]  o_position,
  output logic [indicator_width-1:0]             o_array
);

  localparam int unsigned CW = ch_width(channels);
  localparam int unsigned PW = pos_width(indicator_width);
  localparam int unsigned NW = $clog2(section_sample_count);
  localparam int unsigned HW = count_width(peak_hold_count);

  logic [sample_width-1:0] min_q  [channels];
  logic [sample_width-1:0] max_q  [channels];
  logic [NW-1:0]           cnt_q  [channels];
  logic [PW-1:0]           peak_q [channels];
  logic [HW-1:0]           hold_q [channels];

  logic                    pend_valid_q, pend_valid_d;
  logic [CW-1:0]           pend_ch_q;
  logic [sample_width-1:0] pend_diff_q;

  logic                       o_valid_q, o_valid_d;
  logic [CW-1:0]              o_channel_q;
  logic [PW-1:0]              o_position_q;
  logic [indicator_width-1:0] o_array_q;

  logic                    ch_ok, accept, sec_done, fire;
  logic [CW-1:0]           ch_idx;
  logic [sample_width-1:0] u, min_n, max_n;
  logic [PW-1:0]           pos, peak_n;
  logic [HW-1:0]           hold_n;
  logic [indicator_width-1:0] bar;

  assign i_ready = !reset & (!pend_valid_q | !o_valid_q | o_ready);
  assign fire    = pend_valid_q & (!o_valid_q | o_ready);

  // Stage 1: per-channel running min/max and section completion.
  always_comb begin
    u        = sample_width'(to_offset(64'(i_value), sample_width));
    ch_ok    = 32'(i_channel) < channels;
    ch_idx   = ch_ok ? i_channel : '0;
    accept   = i_valid & i_ready & ch_ok;
    min_n    = u;
    max_n    = u;
    if (cnt_q[ch_idx] != '0) begin
      min_n = (u < min_q[ch_idx]) ? u : min_q[ch_idx];
      max_n = (u > max_q[ch_idx]) ? u : max_q[ch_idx];
    end
    sec_done = accept & (cnt_q[ch_idx] == NW'(section_sample_count - 1));
  end

  level_to_position #(
    .sample_width    (sample_width),
    .indicator_width (indicator_width),
    .log_scale       (log_scale)
  ) u_l2p (
    .diff_i (pend_diff_q),
    .pos_o  (pos)
  );

  // Stage 2: peak hold/decay and bar with peak marker for the pending section.
  always_comb begin
    peak_n = peak_q[pend_ch_q];
    hold_n = hold_q[pend_ch_q];
    if (pos >= peak_n) begin
      peak_n = pos;
      hold_n = HW'(peak_hold_count);
    end else if (hold_n != '0) begin
      hold_n = hold_n - HW'(1);
    end else if (peak_n != '0) begin
      peak_n = peak_n - PW'(1);
    end
    for (int unsigned i = 0; i < indicator_width; i++) begin
      bar[i] = (PW'(i) < pos) | ((peak_n != '0) && (PW'(i) == peak_n - PW'(1)));
    end
  end

  always_comb begin
    pend_valid_d = pend_valid_q;
    if (sec_done)  pend_valid_d = 1'b1;
    else if (fire) pend_valid_d = 1'b0;
    o_valid_d = o_valid_q;
    if (fire)         o_valid_d = 1'b1;
    else if (o_ready) o_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < channels; c++) begin
        min_q[c]  <= '0;
        max_q[c]  <= '0;
        cnt_q[c]  <= '0;
        peak_q[c] <= '0;
        hold_q[c] <= '0;
      end
      pend_valid_q <= 1'b0;
      pend_ch_q    <= '0;
      pend_diff_q  <= '0;
      o_valid_q    <= 1'b0;
      o_channel_q  <= '0;
      o_position_q <= '0;
      o_array_q    <= '0;
    end else begin
      if (accept) begin
        min_q[ch_idx] <= min_n;
        max_q[ch_idx] <= max_n;
        cnt_q[ch_idx] <= cnt_q[ch_idx] + NW'(1);
      end
      pend_valid_q <= pend_valid_d;
      if (sec_done) begin
        pend_ch_q   <= ch_idx;
        pend_diff_q <= max_n - min_n;
      end
      if (fire) begin
        peak_q[pend_ch_q] <= peak_n;
        hold_q[pend_ch_q] <= hold_n;
        o_channel_q       <= pend_ch_q;
        o_position_q      <= pos;
        o_array_q         <= bar;
      end
      o_valid_q <= o_valid_d;
    end
  end

  assign o_valid    = o_valid_q;
  assign o_channel  = o_channel_q;
  assign o_position = o_position_q;
  assign o_array    = o_array_q;

endmodule

// File: tb/tb_audio_level_meter_multi.sv
// Bench: three meter variants (log, linear, short peak hold) on shared stimulus.
module tb_audio_level_meter_multi;

  localparam int NI = 3;

  logic        clk;
  logic        reset;
  logic        i_valid;
  logic [0:0]  i_channel;
  logic [15:0] i_value;
  logic        o_ready;

  logic        i_ready_w    [NI];
  logic        o_valid_w    [NI];
  logic [0:0]  o_channel_w  [NI];
  logic [5:0]  o_position_w [NI];
  logic [31:0] o_array_w    [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    audio_level_meter_multi #(
      .channels             (2),
      .sample_width         (16),
      .indicator_width      (32),
      .section_sample_count (32),
      .peak_hold_count      ((k == 2) ? 2 : 13781),
      .log_scale            ((k == 1) ? 0 : 1)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .i_valid    (i_valid),
      .i_ready    (i_ready_w[k]),
      .i_channel  (i_channel),
      .i_value    (i_value),
      .o_valid    (o_valid_w[k]),
      .o_ready    (o_ready),
      .o_channel  (o_channel_w[k]),
      .o_position (o_position_w[k]),
      .o_array    (o_array_w[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [0:0]       ch;
    logic [2:0][5:0]  pos;
    logic [2:0][31:0] arr;
  } exp_t;

  exp_t expq[$];
  int   smp   [2][32];
  int   n_smp [2];
  int   pk    [NI][2];
  int   hd    [NI][2];

  function automatic int pos_of(input int diff, input bit lg);
    int len;
    if (lg) begin
      len = (diff == 0) ? 0 : $clog2(diff + 1);
      return (len * 32) / 16;
    end
    return int'((longint'(diff) * 32 + 65535) / 65536);
  endfunction

  task automatic section_done(input int ch);
    int mx, mn, p, phc;
    longint a;
    exp_t e;
    mx = smp[ch][0];
    mn = smp[ch][0];
    for (int i = 1; i < 32; i++) begin
      if (smp[ch][i] > mx) mx = smp[ch][i];
      if (smp[ch][i] < mn) mn = smp[ch][i];
    end
    e = '0;
    e.ch = 1'(ch);
    for (int k = 0; k < NI; k++) begin
      p = pos_of(mx - mn, k != 1);
      phc = (k == 2) ? 2 : 13781;
      if (p >= pk[k][ch]) begin pk[k][ch] = p; hd[k][ch] = phc; end
      else if (hd[k][ch] > 0) hd[k][ch]--;
      else if (pk[k][ch] > 0) pk[k][ch]--;
      a = (p == 0) ? 64'd0 : ((64'd1 << p) - 64'd1);
      if (pk[k][ch] != 0) a = a | (64'd1 << (pk[k][ch] - 1));
      e.pos[k] = 6'(p);
      e.arr[k] = 32'(a);
    end
    expq.push_back(e);
  endtask

  logic        held;
  logic [31:0] h_arr [NI];
  logic [5:0]  h_pos [NI];
  logic [0:0]  h_ch  [NI];

  // Model update and per-cycle output comparison.
  always @(negedge clk) begin
    if (reset) begin
      expq.delete();
      held = 1'b0;
      for (int c = 0; c < 2; c++) begin
        n_smp[c] = 0;
        for (int k = 0; k < NI; k++) begin pk[k][c] = 0; hd[k][c] = 0; end
      end
    end else begin
      if (held && o_valid_w[0]) begin
        for (int k = 0; k < NI; k++) begin
          chk($sformatf("stable%0d_arr", k), o_array_w[k], h_arr[k]);
          chk($sformatf("stable%0d_pos", k), o_position_w[k], h_pos[k]);
          chk($sformatf("stable%0d_ch", k), o_channel_w[k], h_ch[k]);
        end
      end
      held = 1'b0;
      if (o_valid_w[0] && !o_ready) begin
        held = 1'b1;
        for (int k = 0; k < NI; k++) begin
          h_arr[k] = o_array_w[k]; h_pos[k] = o_position_w[k]; h_ch[k] = o_channel_w[k];
        end
      end
      if (o_valid_w[0] && o_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          for (int k = 0; k < NI; k++) begin
            chk($sformatf("out%0d_valid", k), o_valid_w[k], 1);
            chk($sformatf("out%0d_ch", k), o_channel_w[k], e.ch);
            chk($sformatf("out%0d_pos", k), o_position_w[k], e.pos[k]);
            chk($sformatf("out%0d_arr", k), o_array_w[k], e.arr[k]);
          end
        end
      end
      if (i_valid && i_ready_w[0]) begin
        int c;
        c = int'(i_channel);
        smp[c][n_smp[c]] = int'($signed(i_value));
        n_smp[c]++;
        if (n_smp[c] == 32) begin
          section_done(c);
          n_smp[c] = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int ch, input int v);
    @(posedge clk); #1;
    i_valid   = 1'b1;
    i_channel = 1'(ch);
    i_value   = 16'(v);
    for (int w = 0; w < 500; w++) begin
      @(negedge clk);
      if (i_ready_w[0]) return;
    end
    chk("send_timeout", 0, 1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_result();
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (o_valid_w[0]) return;
    end
    chk("result_timeout", 0, 1);
  endtask

  initial begin
    automatic logic [31:0] decay_arr [5] = '{32'h8000_0000, 32'h8000_0000,
                                             32'h4000_0000, 32'h2000_0000, 32'h1000_0000};
    reset = 1'b1; i_valid = 1'b0; i_channel = '0; i_value = '0; o_ready = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst%0d_valid", k), o_valid_w[k], 0);
      chk($sformatf("rst%0d_ch", k), o_channel_w[k], 0);
      chk($sformatf("rst%0d_pos", k), o_position_w[k], 0);
      chk($sformatf("rst%0d_arr", k), o_array_w[k], 0);
      chk($sformatf("rst%0d_iready", k), i_ready_w[k], 0);
    end
    @(posedge clk); #1; reset = 1'b0;

    // +/-1000 on ch0: log pos 22, linear pos 1, two-cycle latency
    for (int i = 0; i < 32; i++) send(0, (i % 2) ? -1000 : 1000);
    idle();
    @(negedge clk);
    chk("lat_t1_valid", o_valid_w[0], 0);
    @(negedge clk);
    chk("lat_t2_valid", o_valid_w[0], 1);
    chk("t1_ch", o_channel_w[0], 0);
    chk("t1_log_pos", o_position_w[0], 22);
    chk("t1_log_arr", o_array_w[0], 32'h003F_FFFF);
    chk("t1_lin_pos", o_position_w[1], 1);
    chk("t1_lin_arr", o_array_w[1], 32'h0000_0001);

    // interleaved full scale ch0 / silence ch1
    for (int i = 0; i < 32; i++) begin
      send(0, (i % 2) ? -32768 : 32767);
      send(1, 0);
    end
    idle();
    wait_result();
    chk("fs_ch0_ch", o_channel_w[0], 0);
    chk("fs_ch0_log_arr", o_array_w[0], 32'hFFFF_FFFF);
    chk("fs_ch0_lin_arr", o_array_w[1], 32'hFFFF_FFFF);
    wait_result();
    chk("fs_ch1_ch", o_channel_w[0], 1);
    chk("fs_ch1_pos", o_position_w[0], 0);
    chk("fs_ch1_arr", o_array_w[0], 0);

    // silent ch0 sections: short-hold peak decays one segment per section
    for (int s = 0; s < 5; s++) begin
      for (int i = 0; i < 32; i++) send(0, 0);
      idle();
      wait_result();
      chk($sformatf("decay%0d_arr", s), o_array_w[2], decay_arr[s]);
      chk($sformatf("hold%0d_log_arr", s), o_array_w[0], 32'h8000_0000);
    end

    // backpressure: two sections complete while the sink stalls
    @(posedge clk); #1; o_ready = 1'b0;
    for (int i = 0; i < 32; i++) send(1, (i % 2) ? -100 : 100);
    for (int i = 0; i < 32; i++) send(1, (i % 2) ? -5000 : 5000);
    idle();
    repeat (3) @(negedge clk);
    chk("bp_iready", i_ready_w[0], 0);
    chk("bp_valid", o_valid_w[0], 1);
    chk("bp_first_pos", o_position_w[0], 16);
    chk("bp_first_arr", o_array_w[0], 32'h0000_FFFF);
    @(posedge clk); #1; o_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_second_valid", o_valid_w[0], 1);
    chk("bp_second_log_pos", o_position_w[0], 28);
    chk("bp_second_lin_pos", o_position_w[1], 5);
    chk("bp_second_arr", o_array_w[0], 32'h0FFF_FFFF);
    for (int i = 0; i < 32; i++) send(1, (i % 2) ? -3 : 3);
    idle();
    wait_result();
    chk("cont_pos", o_position_w[0], 6);

    // reset after a partial ch0 section
    for (int i = 0; i < 10; i++) send(0, (i % 2) ? -20000 : 20000);
    idle();
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_iready", i_ready_w[0], 0);
    @(negedge clk);
    chk("mid_rst_valid", o_valid_w[0], 0);
    chk("mid_rst_arr", o_array_w[0], 0);
    @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < 32; i++) send(0, (i % 2) ? -300 : 300);
    idle();
    @(negedge clk);
    chk("post_rst_early", o_valid_w[0], 0);
    @(negedge clk);
    chk("post_rst_valid", o_valid_w[0], 1);
    chk("post_rst_pos", o_position_w[0], 20);
    chk("post_rst_arr", o_array_w[0], 32'h000F_FFFF);

    for (int w = 0; w < 100 && expq.size() != 0; w++) @(negedge clk);
    @(negedge clk);
    chk("drain", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
